// File: rtl/toggle_event_decoder_if.sv
// toggle_event_decoder_if: bundles the toggle line, the pending-event
// handshake and the status outputs of toggle_event_decoder.
//
// Handshake: evt_valid is high while at least one detected event is
// pending. One event is consumed on every rising clk edge where both
// evt_valid and evt_ready are high. evt_valid does not depend
// combinationally on evt_ready. evt_ready may be held high while evt_valid
// is low; that has no effect.
interface toggle_event_decoder_if #(
    parameter int CNT_W  = 8,
    parameter int PEND_W = 4
);
    logic              t_in;
    logic              evt_ready;
    logic              clr_ovf;
    logic              pulse;
    logic              evt_valid;
    logic [PEND_W-1:0] pending;
    logic [CNT_W-1:0]  evt_count;
    logic              overflow;

    // Decoder side.
    modport master (
        input  t_in, evt_ready, clr_ovf,
        output pulse, evt_valid, pending, evt_count, overflow
    );

    // Transmitter and consumer side.
    modport slave (
        output t_in, evt_ready, clr_ovf,
        input  pulse, evt_valid, pending, evt_count, overflow
    );
endinterface

// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder: synchronises an asynchronous toggle line into clk.
// Each level change is turned into a one-cycle pulse and a queued pending
// event. The block also keeps a wrapping event count and a sticky overflow
// flag.
//
// Optional build macro TOGGLE_DEC_GLITCH_FILTER_EN: a change is accepted only
// if the synchroniser output differs from the reference level on two
// consecutive cycles. This adds one cycle of latency.
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int PEND_W      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    toggle_event_decoder_if.master        bus,
    output logic                          o_dbg_state
);
    localparam int                PRIME_W    = $clog2(SYNC_STAGES);
    localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(SYNC_STAGES - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX   = '1;

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                 r_state;
    logic [PRIME_W-1:0]     r_prime_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_ref;
    logic                   r_pulse;
    logic                   r_evt_valid;
    logic [PEND_W-1:0]      r_pending;
    logic [CNT_W-1:0]       r_evt_count;
    logic                   r_overflow;
`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
    logic                   r_filt;
`endif

    logic [SYNC_STAGES-1:0] w_sync_next;
    logic                   w_sync_out;
    logic                   w_differ;
    logic                   w_toggle;
    logic                   w_accept;
    logic [PEND_W-1:0]      w_pending_next;
    logic                   w_ovf_set;

    assign w_sync_next = {r_sync[SYNC_STAGES-2:0], bus.t_in};
    assign w_sync_out  = r_sync[SYNC_STAGES-1];
    assign w_differ    = (r_state == ST_RUN) && (w_sync_out != r_ref);
`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
    assign w_toggle    = w_differ && r_filt;
`else
    assign w_toggle    = w_differ;
`endif
    assign w_accept    = r_evt_valid && bus.evt_ready;

    // Pending-count arithmetic. It saturates at the maximum and flags overflow instead of wrapping.
    always_comb begin
        w_pending_next = r_pending;
        w_ovf_set      = 1'b0;
        if (w_toggle && !w_accept) begin
            if (r_pending == PEND_MAX) begin
                w_ovf_set = 1'b1;
            end else begin
                w_pending_next = r_pending + 1'b1;
            end
        end else if (!w_toggle && w_accept) begin
            // evt_valid mirrors pending != 0, so this cannot underflow.
            w_pending_next = r_pending - 1'b1;
        end
    end

    // Synchroniser, PRIME/RUN state machine and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_PRIME;
            r_prime_cnt <= '0;
            r_sync      <= '0;
            r_ref       <= 1'b0;
            r_pulse     <= 1'b0;
            r_evt_valid <= 1'b0;
            r_pending   <= '0;
            r_evt_count <= '0;
            r_overflow  <= 1'b0;
`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
            r_filt      <= 1'b0;
`endif
        end else begin
            r_sync      <= w_sync_next;
            r_pulse     <= w_toggle;
            r_pending   <= w_pending_next;
            r_evt_valid <= (w_pending_next != '0);
            if (w_toggle) begin
                r_evt_count <= r_evt_count + 1'b1;
            end
            // Overflow is set and then cleared; if both happen in one cycle, the set wins.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_overflow <= 1'b0;
            end
            case (r_state)
                ST_PRIME: begin
`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
                    r_filt <= 1'b0;
`endif
                    if (r_prime_cnt == PRIME_LAST) begin
                        // Take the level the chain is about to present. This way, a line
                        // that was already high through reset does not count as an event.
                        r_ref   <= w_sync_next[SYNC_STAGES-1];
                        r_state <= ST_RUN;
                    end else begin
                        r_prime_cnt <= r_prime_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
                    if (w_toggle) begin
                        r_ref  <= w_sync_out;
                        r_filt <= 1'b0;
                    end else begin
                        r_filt <= w_differ;
                    end
`else
                    if (w_toggle) begin
                        r_ref <= w_sync_out;
                    end
`endif
                end
                default: r_state <= ST_PRIME;
            endcase
        end
    end

    assign bus.pulse     = r_pulse;
    assign bus.evt_valid = r_evt_valid;
    assign bus.pending   = r_pending;
    assign bus.evt_count = r_evt_count;
    assign bus.overflow  = r_overflow;
    assign o_dbg_state   = r_state;
endmodule
